// File: rtl/fb_write_arbiter.sv
// Framebuffer write arbiter: round-robin between two pixel writers plus a full-screen clear sweep.
// Optional macro FB_WRITE_BOUNDS_CHECK_EN drops out-of-range writes and pulses o_Oob_Error.
module fb_write_arbiter #(
   parameter int BITS_PER_PIXEL    = 4,
   parameter int FRAMEBUFFER_DEPTH = 307200
) (
   input  logic                      i_Clock,
   input  logic                      i_Reset,
   input  logic                      i_Req0_Valid,
   input  logic [31:0]               i_Req0_Addr,
   input  logic [BITS_PER_PIXEL-1:0] i_Req0_Data,
   output logic                      o_Req0_Ready,
   input  logic                      i_Req1_Valid,
   input  logic [31:0]               i_Req1_Addr,
   input  logic [BITS_PER_PIXEL-1:0] i_Req1_Data,
   output logic                      o_Req1_Ready,
   input  logic                      i_Clear_Start,
   input  logic [BITS_PER_PIXEL-1:0] i_Clear_Data,
   output logic                      o_Clear_Busy,
   output logic                      o_Clear_Done,
   output logic                      o_Write_Enable,
   output logic [31:0]               o_Write_Addr,
   output logic [BITS_PER_PIXEL-1:0] o_Write_Data,
   output logic                      o_Oob_Error
);

   localparam int CNT_W = (FRAMEBUFFER_DEPTH > 1) ? $clog2(FRAMEBUFFER_DEPTH) : 1;
   localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(FRAMEBUFFER_DEPTH - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t                    state, state_next;
   logic [CNT_W-1:0]          clear_count;
   logic [BITS_PER_PIXEL-1:0] clear_colour;
   logic                      last_grant;
   logic                      grant;
   logic                      accept_ok;
   logic                      xfer;
   logic                      clear_go;
   logic                      sweep_last;
   logic                      addr_oob;
   logic [31:0]               sel_addr;
   logic [BITS_PER_PIXEL-1:0] sel_data;

   // Tie goes to whichever requester did not win the last completed transfer.
   always_comb begin
      grant = 1'b0;
      if (i_Req0_Valid && i_Req1_Valid)
         grant = ~last_grant;
      else if (i_Req1_Valid)
         grant = 1'b1;
   end

   assign accept_ok    = !i_Reset && (state == IDLE) && !i_Clear_Start;
   assign o_Req0_Ready = accept_ok && i_Req0_Valid && !grant;
   assign o_Req1_Ready = accept_ok && i_Req1_Valid && grant;
   assign xfer         = o_Req0_Ready || o_Req1_Ready;
   assign sel_addr     = grant ? i_Req1_Addr : i_Req0_Addr;
   assign sel_data     = grant ? i_Req1_Data : i_Req0_Data;
   assign o_Clear_Busy = (state == CLEAR);

   always_ff @(posedge i_Clock) begin
      if (i_Reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      clear_go   = 1'b0;
      sweep_last = 1'b0;
      case (state)
         IDLE: begin
            if (i_Clear_Start) begin
               state_next = CLEAR;
               clear_go   = 1'b1;
            end
         end
         CLEAR: begin
            if (clear_count == LAST_ADDR) begin
               state_next = IDLE;
               sweep_last = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         clear_count    <= '0;
         clear_colour   <= '0;
         last_grant     <= 1'b1;
         o_Write_Enable <= 1'b0;
         o_Write_Addr   <= '0;
         o_Write_Data   <= '0;
         o_Clear_Done   <= 1'b0;
      end else begin
         o_Write_Enable <= 1'b0;
         o_Clear_Done   <= 1'b0;
         if (clear_go) begin
            clear_colour <= i_Clear_Data;
            clear_count  <= '0;
         end else if (state == CLEAR) begin
            o_Write_Enable <= 1'b1;
            o_Write_Addr   <= 32'(clear_count);
            o_Write_Data   <= clear_colour;
            o_Clear_Done   <= sweep_last;
            clear_count    <= sweep_last ? '0 : clear_count + 1'b1;
         end else if (xfer) begin
            last_grant <= grant;
            if (!addr_oob) begin
               o_Write_Enable <= 1'b1;
               o_Write_Addr   <= sel_addr;
               o_Write_Data   <= sel_data;
            end
         end
      end
   end

`ifdef FB_WRITE_BOUNDS_CHECK_EN
   logic oob_q;

   assign addr_oob = (sel_addr >= 32'(FRAMEBUFFER_DEPTH));

   // Out-of-range writes still handshake so the requester never stalls on them.
   always_ff @(posedge i_Clock) begin
      if (i_Reset)
         oob_q <= 1'b0;
      else
         oob_q <= xfer && addr_oob;
   end

   assign o_Oob_Error = oob_q;
`else
   assign addr_oob    = 1'b0;
   assign o_Oob_Error = 1'b0;
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Randomized self-checking bench for fb_write_arbiter (FRAMEBUFFER_DEPTH=16) against a behavioural model.
module tb_fb_write_arbiter;

   localparam int BPP   = 4;
   localparam int DEPTH = 16;

   logic            clock = 1'b0;
   logic            reset;
   logic            req0_valid, req1_valid;
   logic [31:0]     req0_addr, req1_addr;
   logic [BPP-1:0]  req0_data, req1_data;
   logic            req0_ready, req1_ready;
   logic            clear_start;
   logic [BPP-1:0]  clear_data;
   logic            clear_busy, clear_done;
   logic            write_enable;
   logic [31:0]     write_addr;
   logic [BPP-1:0]  write_data;
   logic            oob_error;

   int total = 0;
   int bad   = 0;

   // Behavioural model of the arbiter
   int              m_busy   = 0;
   int              m_idx    = 0;
   int              m_last   = 1;
   logic [BPP-1:0]  m_colour = '0;

   always #5 clock = ~clock;

   fb_write_arbiter #(
      .BITS_PER_PIXEL   (BPP),
      .FRAMEBUFFER_DEPTH(DEPTH)
   ) dut (
      .i_Clock       (clock),
      .i_Reset       (reset),
      .i_Req0_Valid  (req0_valid),
      .i_Req0_Addr   (req0_addr),
      .i_Req0_Data   (req0_data),
      .o_Req0_Ready  (req0_ready),
      .i_Req1_Valid  (req1_valid),
      .i_Req1_Addr   (req1_addr),
      .i_Req1_Data   (req1_data),
      .o_Req1_Ready  (req1_ready),
      .i_Clear_Start (clear_start),
      .i_Clear_Data  (clear_data),
      .o_Clear_Busy  (clear_busy),
      .o_Clear_Done  (clear_done),
      .o_Write_Enable(write_enable),
      .o_Write_Addr  (write_addr),
      .o_Write_Data  (write_data),
      .o_Oob_Error   (oob_error)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, observed, expected);
      end
   endtask

   // One clock cycle: drive, check handshake, advance the model, check the registered port.
   task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [BPP-1:0] d0,
                                input logic v1, input logic [31:0] a1, input logic [BPP-1:0] d1,
                                input logic clr, input logic [BPP-1:0] cd, input logic rst,
                                output int winner);
      int             exp_we, exp_done, exp_oob, check_addr;
      logic [31:0]    exp_addr;
      logic [BPP-1:0] exp_data;
      reset = rst;
      req0_valid = v0; req0_addr = a0; req0_data = d0;
      req1_valid = v1; req1_addr = a1; req1_data = d1;
      clear_start = clr; clear_data = cd;
      #1;
      winner = -1;
      if (!rst && m_busy == 0 && !clr) begin
         if (v0 && v1)  winner = 1 - m_last;
         else if (v0)   winner = 0;
         else if (v1)   winner = 1;
      end
      checkOutput("ready0", 32'(req0_ready), 32'(winner == 0));
      checkOutput("ready1", 32'(req1_ready), 32'(winner == 1));

      exp_we = 0; exp_done = 0; exp_oob = 0; check_addr = 0;
      exp_addr = '0; exp_data = '0;
      if (rst) begin
         m_busy = 0; m_idx = 0; m_last = 1;
         check_addr = 1;
      end else if (m_busy != 0) begin
         exp_we = 1; check_addr = 1;
         exp_addr = 32'(m_idx); exp_data = m_colour;
         exp_done = (m_idx == DEPTH - 1) ? 1 : 0;
         m_idx++;
         if (exp_done != 0) m_busy = 0;
      end else if (clr) begin
         m_busy = 1; m_idx = 0; m_colour = cd;
      end else if (winner >= 0) begin
         m_last   = winner;
         exp_addr = (winner == 1) ? a1 : a0;
         exp_data = (winner == 1) ? d1 : d0;
         exp_we   = 1;
`ifdef FB_WRITE_BOUNDS_CHECK_EN
         if (exp_addr >= 32'(DEPTH)) begin
            exp_we  = 0;
            exp_oob = 1;
         end
`endif
         check_addr = exp_we;
      end

      @(posedge clock);
      #1;
      checkOutput("write_en", 32'(write_enable), 32'(exp_we));
      if (check_addr != 0) begin
         checkOutput("write_addr", write_addr, exp_addr);
         checkOutput("write_data", 32'(write_data), 32'(exp_data));
      end
      checkOutput("clear_done", 32'(clear_done), 32'(exp_done));
      checkOutput("oob_error", 32'(oob_error), 32'(exp_oob));
      checkOutput("clear_busy", 32'(clear_busy), 32'(m_busy));
   endtask

   initial begin
      int             w;
      logic           p0, p1, clr, rst;
      logic [31:0]    pa0, pa1;
      logic [BPP-1:0] pd0, pd1;

      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, w);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, w);

      // Contested requests straight out of reset alternate 0,1,0,1
      for (int i = 0; i < 4; i++)
         applyStimulus(1, 1, 4'h6, 1, 2, 4'h9, 0, 0, 0, w);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, w);

      applyStimulus(1, 5, 4'hA, 0, 0, 0, 0, 0, 0, w);

      // Clear sweep with requester 1 waiting and a stray restart mid-sweep
      p1 = 1'b1;
      applyStimulus(0, 0, 0, 1, 9, 4'h7, 1, 4'h3, 0, w);
      for (int i = 0; i < 20 && p1; i++) begin
         applyStimulus(0, 0, 0, 1, 9, 4'h7, (i == 5), 4'hC, 0, w);
         if (w == 1) p1 = 1'b0;
      end
      checkOutput("req1_after_clear", 32'(p1), 32'h0);

      // Reset mid-sweep at counter 7
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'h5, 0, w);
      for (int i = 0; i < 20 && m_idx != 7; i++)
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, w);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, w);
      for (int i = 0; i < 3; i++)
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, w);

      applyStimulus(1, 16, 4'h5, 0, 0, 0, 0, 0, 0, w);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, w);

      p0 = 1'b0; p1 = 1'b0;
      pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
      for (int i = 0; i < 600; i++) begin
         if (!p0 && $urandom_range(0, 1) == 1) begin
            p0 = 1'b1; pa0 = 32'($urandom_range(0, DEPTH + 3)); pd0 = BPP'($urandom);
         end
         if (!p1 && $urandom_range(0, 1) == 1) begin
            p1 = 1'b1; pa1 = 32'($urandom_range(0, DEPTH + 3)); pd1 = BPP'($urandom);
         end
         clr = ($urandom_range(0, 39) == 0);
         rst = ($urandom_range(0, 149) == 0);
         applyStimulus(p0, pa0, pd0, p1, pa1, pd1, clr, BPP'($urandom), rst, w);
         if (w == 0) p0 = 1'b0;
         if (w == 1) p1 = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
